// File: rtl/color_rank_if.sv
// Pixel ingest and ranked-result handshake bundle for color_rank_engine.
// master drives pixels/start/out_ready; slave is the engine.
interface color_rank_if #(
  parameter int NUM_IMG = 32,
  parameter int CH_W    = 8,
  parameter int FRAC_W  = 2
);
  localparam int IDX_W = $clog2(NUM_IMG);
  localparam int AVG_W = CH_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [3*CH_W-1:0] in_pixel;
  logic              in_last;
  logic [IDX_W-1:0]  in_img_idx;
  logic              start;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_color;
  logic [IDX_W-1:0]  out_img_idx;
  logic [AVG_W-1:0]  out_avg;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_pixel, in_last, in_img_idx,
    output start, out_ready,
    input  in_ready, out_valid, out_color,
    input  out_img_idx, out_avg, busy, done
  );

  modport slave (
    input  in_valid, in_pixel, in_last, in_img_idx,
    input  start, out_ready,
    output in_ready, out_valid, out_color,
    output out_img_idx, out_avg, busy, done
  );
endinterface

// File: rtl/color_rank_engine.sv
// Per-image dominant colour/average extraction, then {colour,avg} ranking.
// Define COLOR_RANK_DESCEND_EN for descending rank order.
module color_rank_engine #(
  parameter int NUM_IMG = 32,
  parameter int CH_W    = 8,
  parameter int CNT_W   = 15,
  parameter int FRAC_W  = 2
) (
  input logic         clk,
  input logic         reset,
  color_rank_if.slave io
);
  localparam int IDX_W = $clog2(NUM_IMG);
  localparam int AVG_W = CH_W + FRAC_W;
  localparam int SUM_W = CH_W + CNT_W;
  localparam int DV_W  = SUM_W + FRAC_W;
  localparam int BIT_W = $clog2(AVG_W);
  localparam int KEY_W = 2 + AVG_W;
  localparam int K_W   = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_STORE, S_SORT, S_OUT
  } state_e;

  state_e state_q;

  logic [CNT_W-1:0] cnt_q [3];
  logic [SUM_W-1:0] sum_q [3];
  logic             px_any_q;
  logic [IDX_W-1:0] idx_q;
  logic [BIT_W-1:0] bit_q;
  logic [DV_W-1:0]  rem_q;
  logic [AVG_W-1:0] quo_q;

  logic [NUM_IMG-1:0] valid_q;
  logic [NUM_IMG-1:0] used_q;
  logic [1:0]         color_q [NUM_IMG];
  logic [AVG_W-1:0]   avg_q [NUM_IMG];
  logic [IDX_W-1:0]   rank_q [NUM_IMG];

  logic [IDX_W-1:0] scan_q;
  logic [IDX_W-1:0] best_q;
  logic [KEY_W-1:0] best_key_q;
  logic             found_q;
  logic             commit_q;
  logic [K_W-1:0]   k_q;
  logic [K_W-1:0]   pass_q;
  logic [IDX_W-1:0] ptr_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       out_color_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [AVG_W-1:0] out_avg_q;
  logic             busy_q;
  logic             done_q;

  logic [CH_W-1:0] px_r, px_g, px_b;
  logic [1:0]      ch_d;
  logic [CH_W-1:0] val_d;

  assign px_r = io.in_pixel[3*CH_W-1:2*CH_W];
  assign px_g = io.in_pixel[2*CH_W-1:CH_W];
  assign px_b = io.in_pixel[CH_W-1:0];

  always_comb begin
    ch_d  = 2'd2;
    val_d = px_b;
    if (px_r >= px_g && px_r >= px_b) begin
      ch_d  = 2'd0;
      val_d = px_r;
    end else if (px_g >= px_b) begin
      ch_d  = 2'd1;
      val_d = px_g;
    end
  end

  logic [1:0]       dom_d;
  logic [CNT_W-1:0] dom_cnt;
  logic [SUM_W-1:0] dom_sum;

  always_comb begin
    dom_d = 2'd2;
    if (cnt_q[0] >= cnt_q[1] && cnt_q[0] >= cnt_q[2])
      dom_d = 2'd0;
    else if (cnt_q[1] >= cnt_q[2])
      dom_d = 2'd1;
  end

  assign dom_cnt = cnt_q[dom_d];
  assign dom_sum = sum_q[dom_d];

  // Quotient fits in AVG_W bits, so trial-subtract cnt<<bit from MSB down.
  logic [DV_W-1:0] rem_cur_d;
  logic [DV_W-1:0] trial_d;
  logic            take_d;

  assign rem_cur_d = (bit_q == BIT_W'(AVG_W-1))
                   ? {dom_sum, {FRAC_W{1'b0}}} : rem_q;
  assign trial_d   = DV_W'(dom_cnt) << bit_q;
  assign take_d    = (dom_cnt != '0) && (rem_cur_d >= trial_d);

  logic [K_W-1:0] vcnt_d;

  always_comb begin
    vcnt_d = '0;
    for (int i = 0; i < NUM_IMG; i++)
      vcnt_d = vcnt_d + K_W'(valid_q[i]);
  end

  logic [KEY_W-1:0] key_d;
  logic             before_d;
  logic             better_d;
  logic [IDX_W-1:0] first_d;
  logic [IDX_W-1:0] ptr_nx_d;
  logic [IDX_W-1:0] nxt_d;
  logic             last_pass_d;
  logic             last_out_d;

  assign key_d = {color_q[scan_q], avg_q[scan_q]};
`ifdef COLOR_RANK_DESCEND_EN
  assign before_d = key_d > best_key_q;
`else
  assign before_d = key_d < best_key_q;
`endif
  // Strict compare keeps the lowest slot on equal keys.
  assign better_d = valid_q[scan_q] && !used_q[scan_q]
                 && (!found_q || before_d);
  assign first_d  = (pass_q == '0) ? best_q : rank_q[0];
  assign ptr_nx_d = ptr_q + 1'b1;
  assign nxt_d    = rank_q[ptr_nx_d];
  assign last_pass_d = (pass_q == k_q - K_W'(1));
  assign last_out_d  = ({1'b0, ptr_q} == k_q - K_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        sum_q[i] <= '0;
      end
      px_any_q    <= 1'b0;
      idx_q       <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      valid_q     <= '0;
      used_q      <= '0;
      scan_q      <= '0;
      best_q      <= '0;
      best_key_q  <= '0;
      found_q     <= 1'b0;
      commit_q    <= 1'b0;
      k_q         <= '0;
      pass_q      <= '0;
      ptr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_idx_q   <= '0;
      out_avg_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            if (cnt_q[ch_d] != '1) begin
              cnt_q[ch_d] <= cnt_q[ch_d] + 1'b1;
              sum_q[ch_d] <= sum_q[ch_d] + SUM_W'(val_d);
            end
            px_any_q <= 1'b1;
            if (io.in_last) begin
              idx_q      <= io.in_img_idx;
              bit_q      <= BIT_W'(AVG_W-1);
              quo_q      <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_DIV;
            end
          end else if (io.start && !px_any_q) begin
            if (vcnt_d == '0) begin
              done_q <= 1'b1;
            end else begin
              k_q      <= vcnt_d;
              pass_q   <= '0;
              scan_q   <= '0;
              found_q  <= 1'b0;
              commit_q <= 1'b0;
              used_q   <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_SORT;
            end
          end
        end
        S_DIV: begin
          if (take_d) begin
            rem_q        <= rem_cur_d - trial_d;
            quo_q[bit_q] <= 1'b1;
          end else begin
            rem_q <= rem_cur_d;
          end
          if (bit_q == '0)
            state_q <= S_STORE;
          else
            bit_q <= bit_q - 1'b1;
        end
        S_STORE: begin
          color_q[idx_q] <= dom_d;
          avg_q[idx_q]   <= quo_q;
          valid_q[idx_q] <= 1'b1;
          for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
            sum_q[i] <= '0;
          end
          px_any_q   <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        S_SORT: begin
          if (!commit_q) begin
            if (better_d) begin
              best_q     <= scan_q;
              best_key_q <= key_d;
              found_q    <= 1'b1;
            end
            if (scan_q == IDX_W'(NUM_IMG-1))
              commit_q <= 1'b1;
            else
              scan_q <= scan_q + 1'b1;
          end else begin
            rank_q[pass_q[IDX_W-1:0]] <= best_q;
            used_q[best_q] <= 1'b1;
            found_q  <= 1'b0;
            commit_q <= 1'b0;
            scan_q   <= '0;
            if (last_pass_d) begin
              ptr_q       <= '0;
              out_valid_q <= 1'b1;
              out_idx_q   <= first_d;
              out_color_q <= color_q[first_d];
              out_avg_q   <= avg_q[first_d];
              state_q     <= S_OUT;
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (io.out_ready) begin
            if (last_out_d) begin
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_color_q <= '0;
              out_avg_q   <= '0;
              valid_q     <= '0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              ptr_q       <= ptr_nx_d;
              out_idx_q   <= nxt_d;
              out_color_q <= color_q[nxt_d];
              out_avg_q   <= avg_q[nxt_d];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_color   = out_color_q;
  assign io.out_img_idx = out_idx_q;
  assign io.out_avg     = out_avg_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;
endmodule

// File: tb/tb_color_rank_engine.sv
// Bench for color_rank_engine: table of single-image loads plus
// hand sequences for ranking, stalls, empty start and mid-sort reset.
module tb_color_rank_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_rank_if #(.NUM_IMG(32), .CH_W(8), .FRAC_W(2)) bus ();

  color_rank_engine dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  typedef struct packed {
    logic [1:0] c;
    logic [4:0] i;
    logic [9:0] a;
  } ent_t;

  typedef struct {
    logic [3:0][23:0] px;
    int               n;
    logic [4:0]       slot;
    logic [1:0]       c;
    logic [9:0]       a;
  } vec_t;

  ent_t sb [$];
  vec_t tbl [8];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [23:0] p0,
      input logic [23:0] p1, input logic [23:0] p2,
      input logic [23:0] p3, input logic [4:0] s,
      input logic [1:0] c, input logic [9:0] a);
    vec_t v;
    v.px   = {p3, p2, p1, p0};
    v.n    = n;
    v.slot = s;
    v.c    = c;
    v.a    = a;
    return v;
  endfunction

  task automatic beat(input logic [23:0] p, input logic last,
                      input logic [4:0] slot, input logic st);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      w++;
      @(negedge clk);
    end
    if (w == 40) chk("in_ready_timeout", 32'(w), 0);
    bus.in_valid   = 1'b1;
    bus.in_pixel   = p;
    bus.in_last    = last;
    bus.in_img_idx = slot;
    bus.start      = st;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic load_image(input logic [3:0][23:0] px, input int n,
                            input logic [4:0] slot);
    int lo = 0;
    for (int k = 0; k < n; k++)
      beat(px[k], k == n - 1, slot, 1'b0);
    while (bus.in_ready !== 1'b1 && lo < 40) begin
      lo++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 32'(lo), 11);
  endtask

  task automatic run_sort(input int n, input int stall_at,
                          input int stall_len);
    int   got = 0;
    int   st = 0;
    int   cyc = 0;
    ent_t cur;
    ent_t e;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (n == 0) begin
      chk("empty_done", 32'(bus.done), 1);
      chk("empty_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      chk("empty_done_clr", 32'(bus.done), 0);
      chk("empty_valid2", 32'(bus.out_valid), 0);
      chk("empty_busy", 32'(bus.busy), 0);
      return;
    end
    while (got < n && cyc < 3000) begin
      if (bus.out_valid === 1'b1) begin
        cur = {bus.out_color, bus.out_img_idx, bus.out_avg};
        if (got == stall_at && st < stall_len) begin
          if (sb.size() > 0) chk("stall_hold", 32'(cur), 32'(sb[0]));
          bus.out_ready = 1'b0;
          st++;
        end else begin
          if (sb.size() > 0) e = sb.pop_front();
          else e = '1;
          chk("entry", 32'(cur), 32'(e));
          bus.out_ready = 1'b1;
          got++;
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("entries_seen", 32'(got), 32'(n));
    chk("done_pulse", 32'(bus.done), 1);
    chk("out_valid_end", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("done_clear", 32'(bus.done), 0);
    chk("busy_end", 32'(bus.busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(4, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000,
                5'd3, 2'd0, 10'h3FC);
    tbl[1] = mk(3, 24'h101010, 24'h002020, 24'h000030, 24'h0,
                5'd0, 2'd0, 10'h040);
    tbl[2] = mk(1, 24'h00807F, 24'h0, 24'h0, 24'h0,
                5'd31, 2'd1, 10'h200);
    tbl[3] = mk(3, 24'h010203, 24'h010203, 24'h010203, 24'h0,
                5'd7, 2'd2, 10'h00C);
    tbl[4] = mk(3, 24'h050000, 24'h000006, 24'h000007, 24'h0,
                5'd1, 2'd2, 10'h01A);
    tbl[5] = mk(3, 24'h030000, 24'h040000, 24'h040000, 24'h0,
                5'd2, 2'd0, 10'h00E);
    tbl[6] = mk(1, 24'h00FFFF, 24'h0, 24'h0, 24'h0,
                5'd4, 2'd1, 10'h3FC);
    tbl[7] = mk(3, 24'h000001, 24'h000000, 24'h000000, 24'h0,
                5'd10, 2'd0, 10'h000);

    bus.in_valid   = 1'b0;
    bus.in_pixel   = '0;
    bus.in_last    = 1'b0;
    bus.in_img_idx = '0;
    bus.start      = 1'b0;
    bus.out_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_data", 32'({bus.out_color, bus.out_img_idx,
                             bus.out_avg}), 0);

    for (int i = 0; i < 8; i++) begin
      load_image(tbl[i].px, tbl[i].n, tbl[i].slot);
      sb.push_back('{tbl[i].c, tbl[i].slot, tbl[i].a});
      run_sort(1, -1, 0);
    end

    load_image({72'h0, 24'h004000}, 1, 5'd0);
    load_image({72'h0, 24'h800000}, 1, 5'd1);
    load_image({72'h0, 24'h200000}, 1, 5'd2);
`ifdef COLOR_RANK_DESCEND_EN
    sb.push_back('{2'd1, 5'd0, 10'h100});
    sb.push_back('{2'd0, 5'd1, 10'h200});
    sb.push_back('{2'd0, 5'd2, 10'h080});
`else
    sb.push_back('{2'd0, 5'd2, 10'h080});
    sb.push_back('{2'd0, 5'd1, 10'h200});
    sb.push_back('{2'd1, 5'd0, 10'h100});
`endif
    run_sort(3, -1, 0);

    load_image({72'h0, 24'h0000FF}, 1, 5'd9);
    load_image({72'h0, 24'h100000}, 1, 5'd12);
    load_image({72'h0, 24'h0000FF}, 1, 5'd5);
`ifdef COLOR_RANK_DESCEND_EN
    sb.push_back('{2'd2, 5'd5, 10'h3FC});
    sb.push_back('{2'd2, 5'd9, 10'h3FC});
    sb.push_back('{2'd0, 5'd12, 10'h040});
`else
    sb.push_back('{2'd0, 5'd12, 10'h040});
    sb.push_back('{2'd2, 5'd5, 10'h3FC});
    sb.push_back('{2'd2, 5'd9, 10'h3FC});
`endif
    run_sort(3, 1, 5);

    run_sort(0, -1, 0);

    beat(24'h100000, 1'b0, 5'd6, 1'b1);
    chk("start_with_px_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mid_image_busy", 32'(bus.busy), 0);
    chk("mid_image_done", 32'(bus.done), 0);
    load_image({72'h0, 24'h200000}, 1, 5'd6);
    sb.push_back('{2'd0, 5'd6, 10'h060});
    run_sort(1, -1, 0);

    load_image({72'h0, 24'h400000}, 1, 5'd1);
    load_image({72'h0, 24'h004000}, 1, 5'd2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("sort_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_sort_busy", 32'(bus.busy), 0);
    chk("rst_sort_valid", 32'(bus.out_valid), 0);
    chk("rst_sort_ready", 32'(bus.in_ready), 1);
    reset = 1'b0;
    run_sort(0, -1, 0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
